// File: rtl/csa_multiword_seq_pkg.sv
// Shared constants and FSM state type for the multi-word carry-select sequencer.
package csa_multiword_seq_pkg;

    localparam int unsigned CHUNK_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/csa_multiword_seq_csa16.sv
// 16-bit carry-select adder: low byte ripples, high byte is precomputed for both carries.
module csa16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        ci,
    output logic [15:0] s,
    output logic        co
);

    logic [8:0] lo;
    logic [8:0] hi0;
    logic [8:0] hi1;

    always_comb begin
        lo  = {1'b0, a[7:0]}  + {1'b0, b[7:0]} + {8'd0, ci};
        hi0 = {1'b0, a[15:8]} + {1'b0, b[15:8]};
        hi1 = hi0 + 9'd1;
        s   = {(lo[8] ? hi1[7:0] : hi0[7:0]), lo[7:0]};
        co  = lo[8] ? hi1[8] : hi0[8];
    end

endmodule

// File: rtl/csa_multiword_seq.sv
// WIDTH-bit add/sub computed LSB chunk first through a single shared csa16,
// with the inter-chunk carry held in a register.
module csa_multiword_seq
    import csa_multiword_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             busy
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK_W;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               co_q, co_d;

    logic [CHUNK_W-1:0] chunk_a;
    logic [CHUNK_W-1:0] chunk_b;
    logic [CHUNK_W-1:0] chunk_s;
    logic               chunk_co;

    csa16 u_csa16 (
        .a  (chunk_a),
        .b  (chunk_b),
        .ci (carry_q),
        .s  (chunk_s),
        .co (chunk_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)           state_d = ST_RUN;
            ST_RUN:  if (idx_q == IDX_LAST)  state_d = ST_DONE;
            ST_DONE: if (out_ready)          state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE) && !rst;
        out_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    end

    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int unsigned i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDX_W'(i)) begin
                chunk_a = a_q[i*CHUNK_W +: CHUNK_W];
                chunk_b = b_q[i*CHUNK_W +: CHUNK_W];
            end
        end
    end

    // Subtraction is folded into the operand latch: b is inverted and carry-in forced to 1.
    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        co_d    = co_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : ci;
                    idx_d   = '0;
                end
            end
            ST_RUN: begin
                for (int unsigned i = 0; i < NCHUNK; i++) begin
                    if (idx_q == IDX_W'(i)) s_d[i*CHUNK_W +: CHUNK_W] = chunk_s;
                end
                carry_d = chunk_co;
                if (idx_q == IDX_LAST) co_d = chunk_co;
                else                   idx_d = idx_q + IDX_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            co_q    <= co_d;
        end
    end

    assign s  = s_q;
    assign co = co_q;

endmodule

// File: tb/tb_csa_multiword_seq.sv
// Self-checking bench for csa_multiword_seq at WIDTH=64 and WIDTH=16 against an arithmetic model.
module tb_csa_multiword_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        ci, sub;

    logic        iv64, ir64, ov64, or64, co64, busy64;
    logic [63:0] a64, b64, s64;
    logic        iv16, ir16, ov16, or16, co16, busy16;
    logic [15:0] a16, b16, s16;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    csa_multiword_seq #(.WIDTH(64)) u64 (
        .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
        .ci(ci), .sub(sub), .out_valid(ov64), .out_ready(or64), .s(s64), .co(co64),
        .busy(busy64)
    );

    csa_multiword_seq #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .ci(ci), .sub(sub), .out_valid(ov16), .out_ready(or16), .s(s16), .co(co16),
        .busy(busy16)
    );

    // Reference: plain modular arithmetic; co is the unsigned carry (add) or no-borrow flag (sub).
    function automatic void ref_calc(input bit w16, input logic [63:0] aa, input logic [63:0] bb,
                                     input logic cci, input logic ssub,
                                     output logic [63:0] rs, output logic rco);
        logic [63:0] mask;
        logic [63:0] am, bm;
        logic [64:0] sum;
        mask = w16 ? 64'h0000_0000_0000_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        am = aa & mask;
        bm = bb & mask;
        if (ssub) begin
            rs  = (am - bm) & mask;
            rco = (am >= bm);
        end else begin
            sum = {1'b0, am} + {1'b0, bm} + {64'd0, cci};
            rs  = sum[63:0] & mask;
            rco = w16 ? sum[16] : sum[64];
        end
    endfunction

    // Runs one full transaction starting at a negedge; ends at a negedge with the DUT back in IDLE.
    // lat counts edges including the accepting one until out_valid is seen.
    task automatic op(input bit w16, input logic [63:0] aa, input logic [63:0] bb,
                      input logic cci, input logic ssub,
                      output logic [63:0] rs, output logic rco, output int lat, output bit ok);
        int n;
        ok = 1'b1;
        if (w16) begin a16 = aa[15:0]; b16 = bb[15:0]; iv16 = 1'b1; end
        else     begin a64 = aa;       b64 = bb;       iv64 = 1'b1; end
        ci = cci; sub = ssub;
        n = 0;
        while (!(w16 ? ir16 : ir64) && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) ok = 1'b0;
        @(negedge clk);
        iv16 = 1'b0; iv64 = 1'b0;
        lat = 1;
        while (!(w16 ? ov16 : ov64) && lat < 50) begin @(negedge clk); lat++; end
        if (lat >= 50) ok = 1'b0;
        rs  = w16 ? {48'd0, s16} : s64;
        rco = w16 ? co16 : co64;
        if (w16) or16 = 1'b1; else or64 = 1'b1;
        @(negedge clk);
        or16 = 1'b0; or64 = 1'b0;
    endtask

    task automatic check_op(input string name, input bit w16, input logic [63:0] aa,
                            input logic [63:0] bb, input logic cci, input logic ssub,
                            input logic [63:0] exp_s, input logic exp_co);
        logic [63:0] rs;
        logic        rco;
        int          lat;
        bit          ok;
        int          exp_lat;
        exp_lat = w16 ? 2 : 5;
        op(w16, aa, bb, cci, ssub, rs, rco, lat, ok);
        n_cmp++;
        if (!ok || rs !== exp_s || rco !== exp_co || lat != exp_lat) begin
            n_bad++;
            $display("FAIL %s: got s=%h co=%b lat=%0d ok=%0d, want s=%h co=%b lat=%0d",
                     name, rs, rco, lat, ok, exp_s, exp_co, exp_lat);
        end
    endtask

    task automatic test_reset();
        logic [67:0] got, want;
        @(negedge clk);
        a64 = 64'h1234; b64 = 64'h5678; ci = 1'b0; sub = 1'b0; iv64 = 1'b1;
        @(negedge clk);
        iv64 = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if ({ov64, busy64, co64, s64} !== 67'd0) begin
            n_bad++;
            $display("FAIL reset_async: got ov=%b busy=%b co=%b s=%h, want all zero", ov64, busy64, co64, s64);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        want = {1'b1, 1'b0, 1'b0, 1'b0, 64'd0};
        got  = {ir64, ov64, busy64, co64, s64};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL reset_release64: got %h want %h", got, want);
        end
        got  = {ir16, ov16, busy16, co16, 48'd0, s16};
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL reset_release16: got %h want %h", got, want);
        end
    endtask

    task automatic test_add_wrap();
        check_op("add_wrap", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1);
    endtask

    task automatic test_sub();
        check_op("sub_borrow", 1'b0, 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        check_op("sub_noborrow", 1'b0, 64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1);
    endtask

    task automatic test_chunk_carry();
        check_op("chunk_carry", 1'b0, 64'h0000_0000_0000_FFFF, 64'd0, 1'b1, 1'b0, 64'h1_0000, 1'b0);
        check_op("w16_wrap", 1'b1, 64'hFFFF, 64'h0001, 1'b0, 1'b0, 64'd0, 1'b1);
    endtask

    task automatic test_hold();
        logic [63:0] held_s, exp_s;
        logic        held_co, exp_co;
        logic [63:0] na, nb;
        int          n;
        bit          stable;
        held_s = 64'h0123_4567_89AB_CDEF + 64'h1111_2222_3333_4444;
        a64 = 64'h0123_4567_89AB_CDEF; b64 = 64'h1111_2222_3333_4444;
        ci = 1'b0; sub = 1'b0; iv64 = 1'b1;
        @(negedge clk);
        iv64 = 1'b0;
        n = 0;
        while (!ov64 && n < 50) begin @(negedge clk); n++; end
        n_cmp++;
        if (!ov64 || s64 !== held_s || co64 !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_first: got ov=%b s=%h co=%b want ov=1 s=%h co=0", ov64, s64, co64, held_s);
        end
        held_co = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            iv64 = (i % 2 == 0);
            a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
            @(negedge clk);
            if (!ov64 || ir64 || s64 !== held_s || co64 !== held_co) stable = 1'b0;
        end
        n_cmp++;
        if (!stable) begin
            n_bad++;
            $display("FAIL hold_stable: got ov=%b ir=%b s=%h co=%b want ov=1 ir=0 s=%h co=%b",
                     ov64, ir64, s64, co64, held_s, held_co);
        end
        na = 64'h8000_0000_0000_0000; nb = 64'h8000_0000_0000_0001;
        a64 = na; b64 = nb; ci = 1'b1; sub = 1'b0; iv64 = 1'b1; or64 = 1'b1;
        @(negedge clk);
        or64 = 1'b0;
        n_cmp++;
        if (ir64 !== 1'b1 || ov64 !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_release: got ir=%b ov=%b want ir=1 ov=0", ir64, ov64);
        end
        @(negedge clk);
        iv64 = 1'b0;
        n_cmp++;
        if (busy64 !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_accept: got busy=%b want 1", busy64);
        end
        n = 0;
        while (!ov64 && n < 50) begin @(negedge clk); n++; end
        ref_calc(1'b0, na, nb, 1'b1, 1'b0, exp_s, exp_co);
        n_cmp++;
        if (!ov64 || s64 !== exp_s || co64 !== exp_co) begin
            n_bad++;
            $display("FAIL hold_next_op: got ov=%b s=%h co=%b want ov=1 s=%h co=%b",
                     ov64, s64, co64, exp_s, exp_co);
        end
        or64 = 1'b1;
        @(negedge clk);
        or64 = 1'b0;
    endtask

    task automatic test_reset_in_run();
        bit seen;
        logic [63:0] ea, eb, es;
        logic        eco;
        a64 = 64'hFFFF_FFFF_0000_FFFF; b64 = 64'h1; ci = 1'b0; sub = 1'b0; iv64 = 1'b1;
        @(negedge clk);
        iv64 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ov64 || busy64) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_bad++;
            $display("FAIL reset_in_run: got out_valid/busy=1 after abort want 0");
        end
        ea = 64'h0000_FFFF_FFFF_FFFF; eb = 64'h0000_0000_0000_0003;
        ref_calc(1'b0, ea, eb, 1'b0, 1'b0, es, eco);
        check_op("after_abort", 1'b0, ea, eb, 1'b0, 1'b0, es, eco);
    endtask

    task automatic test_back_to_back();
        logic [63:0] aa, bb, rs, es;
        logic        cc, ss, rco, eco;
        int          lat, bad;
        bit          ok, w16;
        for (int i = 0; i < 1000; i++) begin
            w16 = (i % 2 == 1);
            case ($urandom_range(0, 3))
                0:       aa = 64'hFFFF_FFFF_FFFF_FFFF;
                1:       aa = 64'd0;
                default: aa = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 3))
                0:       bb = 64'hFFFF_FFFF_FFFF_FFFF;
                1:       bb = 64'd0;
                default: bb = {$urandom, $urandom};
            endcase
            cc = 1'($urandom_range(0, 1));
            ss = 1'($urandom_range(0, 1));
            ref_calc(w16, aa, bb, cc, ss, es, eco);
            op(w16, aa, bb, cc, ss, rs, rco, lat, ok);
            n_cmp++;
            bad = (!ok || rs !== es || rco !== eco || lat != (w16 ? 2 : 5)) ? 1 : 0;
            if (bad != 0) begin
                n_bad++;
                $display("FAIL rand_%0d w16=%0d a=%h b=%h ci=%b sub=%b: got s=%h co=%b lat=%0d, want s=%h co=%b",
                         i, w16, aa, bb, cc, ss, rs, rco, lat, es, eco);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        iv64 = 1'b0; or64 = 1'b0; a64 = '0; b64 = '0;
        iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0;
        ci = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_add_wrap();
        test_sub();
        test_chunk_carry();
        test_hold();
        test_reset_in_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
